// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scheduler states, urgent page index and glyph table.
// Used by seg7_page_sched and the seven-segment value-display driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        URGENT = 2'd2
    } sched_state_t;

    // The urgent page sits just past the last rotating source.
    function automatic logic [3:0] urg_src(input int nsrc);
        return 4'(nsrc);
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_rr_pick.sv
// seg7_rr_pick: finds the first valid source after cur, wrapping to 0.
// cur itself is searched last, so only_cur flags "nothing else to show".
module seg7_rr_pick
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] src_valid,
    input  logic [2:0]      cur,
    output logic [2:0]      nxt,
    output logic            found,
    output logic            only_cur
);

    logic [7:0] vpad;
    int         j;

    always_comb begin
        vpad = '0;
        vpad[NSRC-1:0] = src_valid;
    end

    // Scan from the far end so the nearest hit is written last.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        j     = 0;
        for (int i = NSRC; i >= 1; i--) begin
            j = int'(cur) + i;
            if (j >= NSRC) j = j - NSRC;
            if (vpad[j[2:0]]) begin
                nxt   = j[2:0];
                found = 1'b1;
            end
        end
    end

    assign only_cur = found && (nxt == cur);

endmodule

// File: rtl/seg7_page_sched.sv
// seg7_page_sched: round-robin page scheduler for the 8-digit display.
// Optional urgent blink enabled by defining SEG7_SCHED_BLINK_EN.
module seg7_page_sched
    import seg7_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int DWELL_CYC = 200_000_000,
    parameter int URG_CYC   = 300_000_000,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic [NSRC-1:0]     src_valid,
    input  logic [16*NSRC-1:0]  src_data,
    input  logic                urg_req,
    input  logic [15:0]         urg_data,
    output logic                urg_ack,
    input  logic                hold,
    input  logic                next_btn,
    output logic [15:0]         disp_value,
    output logic [3:0]          disp_src,
    output logic                disp_load,
    output logic                disp_blank
);

    localparam int MAXC = (DWELL_CYC > URG_CYC) ? DWELL_CYC : URG_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] URG_LAST   = CW'(URG_CYC - 1);
    localparam logic [3:0]    URG_SRC    = urg_src(NSRC);

    if (NSRC < 2 || NSRC > 8 || BLINK_CYC < 1) begin : g_bad_param
        $error("seg7_page_sched: parameter out of range");
    end

    sched_state_t    state, state_n;
    logic [2:0]      cur, cur_n, pick_cur, nxt;
    logic [CW-1:0]   cnt, cnt_n;
    logic [15:0]     val_n, cur_data;
    logic [3:0]      src_n;
    logic            load_n, ack_n, blank_n;
    logic            found, only_cur, cur_ok, adv;

`ifdef SEG7_SCHED_BLINK_EN
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    logic [BW-1:0] bcnt, bcnt_n;
`endif

    // In IDLE, searching from NSRC-1 yields the lowest valid index.
    assign pick_cur = (state == IDLE) ? 3'(NSRC - 1) : cur;

    seg7_rr_pick #(.NSRC(NSRC)) u_pick (
        .src_valid (src_valid),
        .cur       (pick_cur),
        .nxt       (nxt),
        .found     (found),
        .only_cur  (only_cur)
    );

    always_comb begin
        cur_data = '0;
        cur_ok   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (cur == 3'(i)) begin
                cur_data = src_data[16*i +: 16];
                cur_ok   = src_valid[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        val_n   = disp_value;
        src_n   = disp_src;
        load_n  = 1'b0;
        ack_n   = 1'b0;
        blank_n = disp_blank;
        adv     = 1'b0;
`ifdef SEG7_SCHED_BLINK_EN
        bcnt_n  = bcnt;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = SHOW;
                    cur_n   = nxt;
                    src_n   = {1'b0, nxt};
                    load_n  = 1'b1;
                    cnt_n   = '0;
                    blank_n = 1'b0;
                end
            end
            SHOW: begin
                val_n = cur_data;
                adv   = !cur_ok || next_btn ||
                        (!hold && cnt == DWELL_LAST);
                if (!adv && !hold) cnt_n = cnt + CW'(1);
            end
            URGENT: begin
                if (cnt == URG_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                    blank_n = 1'b0;
                    if (cur_ok) begin
                        src_n  = {1'b0, cur};
                        load_n = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (adv) begin
            cnt_n = '0;
            if (!found) begin
                state_n = IDLE;
                blank_n = 1'b1;
            end else if (!only_cur) begin
                cur_n  = nxt;
                src_n  = {1'b0, nxt};
                load_n = 1'b1;
            end
        end

`ifdef SEG7_SCHED_BLINK_EN
        if (state == URGENT && state_n == URGENT) begin
            if (bcnt == BLINK_LAST) begin
                bcnt_n  = '0;
                blank_n = !disp_blank;
            end else begin
                bcnt_n = bcnt + BW'(1);
            end
        end
`endif

        // Urgent capture overrides any rotation decision this cycle.
        if (urg_req) begin
            state_n = URGENT;
            cur_n   = cur;
            cnt_n   = '0;
            val_n   = urg_data;
            src_n   = URG_SRC;
            load_n  = 1'b1;
            ack_n   = 1'b1;
            blank_n = 1'b0;
`ifdef SEG7_SCHED_BLINK_EN
            bcnt_n  = '0;
`endif
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            disp_value <= '0;
            disp_src   <= '0;
            disp_load  <= 1'b0;
            urg_ack    <= 1'b0;
            disp_blank <= 1'b1;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cnt        <= cnt_n;
            disp_value <= val_n;
            disp_src   <= src_n;
            disp_load  <= load_n;
            urg_ack    <= ack_n;
            disp_blank <= blank_n;
        end
    end

`ifdef SEG7_SCHED_BLINK_EN
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) bcnt <= '0;
        else             bcnt <= bcnt_n;
    end
`endif

endmodule

// File: tb/tb_seg7_page_sched.sv
// tb_seg7_page_sched: directed scenario bench with a display-load scoreboard.
// Small timing parameters; blink expectations follow SEG7_SCHED_BLINK_EN.
module tb_seg7_page_sched;

    localparam int NSRC = 4;

`ifdef SEG7_SCHED_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  src;
        logic [15:0] val;
    } exp_t;

    logic                CLK100MHZ = 1'b0;
    logic                CPU_RESETN;
    logic [NSRC-1:0]     src_valid;
    logic [16*NSRC-1:0]  src_data;
    logic                urg_req;
    logic [15:0]         urg_data;
    logic                urg_ack;
    logic                hold;
    logic                next_btn;
    logic [15:0]         disp_value;
    logic [3:0]          disp_src;
    logic                disp_load;
    logic                disp_blank;

    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    seg7_page_sched #(
        .NSRC      (NSRC),
        .DWELL_CYC (10),
        .URG_CYC   (20),
        .BLINK_CYC (4)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .urg_req    (urg_req),
        .urg_data   (urg_data),
        .urg_ack    (urg_ack),
        .hold       (hold),
        .next_btn   (next_btn),
        .disp_value (disp_value),
        .disp_src   (disp_src),
        .disp_load  (disp_load),
        .disp_blank (disp_blank)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic wait_load(input int lim, output int n);
        n = 0;
        do begin
            @(posedge CLK100MHZ);
            #1;
            n++;
        end while (!disp_load && n < lim);
    endtask

    task automatic push(input logic [3:0] s, input logic [15:0] v);
        exp_t e;
        e.src = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every disp_load must match the next expected page.
    initial begin
        exp_t        e;
        logic        pend = 1'b0;
        logic [15:0] pend_val = '0;
        forever begin
            @(negedge CLK100MHZ);
            if (pend) begin
                chk("value_after_load", 32'(disp_value), 32'(pend_val));
                pend = 1'b0;
            end
            if (disp_load) begin
                chk("load_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("load_src", 32'(disp_src), 32'(e.src));
                    if (e.src == 4'(NSRC)) begin
                        chk("urg_value", 32'(disp_value), 32'(e.val));
                    end else begin
                        pend     = 1'b1;
                        pend_val = e.val;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        CPU_RESETN = 1'b0;
        src_valid  = '0;
        for (int i = 0; i < NSRC; i++)
            src_data[16*i +: 16] = 16'h0A00 + 16'(i);
        urg_req  = 1'b0;
        urg_data = '0;
        hold     = 1'b0;
        next_btn = 1'b0;

        step(3);
        chk("rst_blank", 32'(disp_blank), 32'(1));
        chk("rst_value", 32'(disp_value), 32'(0));
        chk("rst_src",   32'(disp_src),   32'(0));
        chk("rst_load",  32'(disp_load),  32'(0));
        chk("rst_ack",   32'(urg_ack),    32'(0));
        CPU_RESETN = 1'b1;
        step(3);
        chk("idle_blank", 32'(disp_blank), 32'(1));
        chk("idle_load",  32'(disp_load),  32'(0));

        // 1: first valid source leaves IDLE
        push(4'd0, 16'h0A00);
        src_valid = 4'b0101;
        step(1);
        chk("entry_load",  32'(disp_load),  32'(1));
        chk("entry_src",   32'(disp_src),   32'(0));
        chk("entry_blank", 32'(disp_blank), 32'(0));
        step(1);
        chk("entry_pulse", 32'(disp_load),  32'(0));

        // 2: dwell rotation over all four sources
        src_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push(4'((k + 1) % 4), 16'h0A00 + 16'((k + 1) % 4));
            wait_load(20, n);
            chk("dwell_cycles", 32'(n), 32'((k == 0) ? 9 : 10));
        end

        // 3: next_btn, invalidated page, hold
        src_valid = 4'b1011;
        push(4'd1, 16'h0A01);
        next_btn = 1'b1;
        step(1);
        next_btn = 1'b0;
        chk("btn_to_1", 32'(disp_src), 32'(1));
        step(1);
        push(4'd3, 16'h0A03);
        next_btn = 1'b1;
        step(1);
        next_btn = 1'b0;
        chk("btn_skip_2", 32'(disp_src), 32'(3));
        push(4'd0, 16'h0A00);
        src_valid = 4'b0011;
        step(1);
        chk("invalid_adv", 32'(disp_src), 32'(0));
        hold = 1'b1;
        step(30);
        chk("hold_src", 32'(disp_src), 32'(0));

        // 4: single valid source never reloads
        hold = 1'b0;
        push(4'd2, 16'h0A02);
        src_valid = 4'b0100;
        step(1);
        chk("single_entry", 32'(disp_src), 32'(2));
        step(35);
        chk("single_stay", 32'(disp_src),  32'(2));
        chk("single_load", 32'(disp_load), 32'(0));

        // 5: urgent beats next_btn, re-request restarts timer
        push(4'd1, 16'h0A01);
        src_valid = 4'b0010;
        step(1);
        chk("to_page1", 32'(disp_src), 32'(1));
        step(2);
        push(4'(NSRC), 16'h0FA5);
        urg_req  = 1'b1;
        urg_data = 16'h0FA5;
        next_btn = 1'b1;
        step(1);
        urg_req  = 1'b0;
        next_btn = 1'b0;
        chk("urg_ack",   32'(urg_ack),    32'(1));
        chk("urg_src",   32'(disp_src),   32'(NSRC));
        chk("urg_value", 32'(disp_value), 32'h0FA5);
        step(1);
        chk("urg_ack_pulse", 32'(urg_ack), 32'(0));
        step(13);
        push(4'(NSRC), 16'h0BEE);
        urg_req  = 1'b1;
        urg_data = 16'h0BEE;
        step(1);
        urg_req = 1'b0;
        chk("reurg_ack",   32'(urg_ack),    32'(1));
        chk("reurg_value", 32'(disp_value), 32'h0BEE);
        push(4'd1, 16'h0A01);
        wait_load(30, n);
        chk("urg_cycles", 32'(n),        32'(20));
        chk("urg_return", 32'(disp_src), 32'(1));

        // 6: reset in the middle of an urgent message
        step(2);
        push(4'(NSRC), 16'h0123);
        urg_req  = 1'b1;
        urg_data = 16'h0123;
        step(1);
        urg_req = 1'b0;
        chk("blink_ph0", 32'(disp_blank), 32'(0));
        step(4);
        chk("blink_ph1", 32'(disp_blank), 32'(BLINK));
        CPU_RESETN = 1'b0;
        src_valid  = '0;
        #1;
        chk("mid_rst_blank", 32'(disp_blank), 32'(1));
        chk("mid_rst_value", 32'(disp_value), 32'(0));
        chk("mid_rst_src",   32'(disp_src),   32'(0));
        chk("mid_rst_ack",   32'(urg_ack),    32'(0));
        chk("mid_rst_load",  32'(disp_load),  32'(0));
        step(2);
        CPU_RESETN = 1'b1;
        step(3);
        chk("post_rst_src",   32'(disp_src),   32'(0));
        chk("post_rst_blank", 32'(disp_blank), 32'(1));
        chk("post_rst_ack",   32'(urg_ack),    32'(0));
        chk("queue_empty",    32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
